// File: rtl/mips_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// mips_ctrl_pkg
//   Shared decode-controller definitions for the 5-stage MIPS datapath.
//   Holds the field encodings that the controller drives (RegDst,
//   JumpInstCont, MemToReg, ALUOp) and the packed control bundle that
//   travels down the pipeline next to the operands.
//   No ports (package).
// ---------------------------------------------------------------------------
package mips_ctrl_pkg;

   // RegDst: which instruction field names the write register
   localparam logic [2:0] RD_RT = 3'd0;
   localparam logic [2:0] RD_RD = 3'd1;
   localparam logic [2:0] RD_RA = 3'd2;   // link register $31 (jal)

   // JumpInstCont
   localparam logic [2:0] JMP_NONE = 3'd0;
   localparam logic [2:0] JMP_J    = 3'd1; // j / jal
   localparam logic [2:0] JMP_JR   = 3'd2; // jr: target read from rs in ID

   // MemToReg: write-back source select
   localparam logic [2:0] MTR_ALU = 3'd0;
   localparam logic [2:0] MTR_MEM = 3'd1;
   localparam logic [2:0] MTR_PC4 = 3'd2;  // link address for jal
   localparam logic [2:0] MTR_LUI = 3'd3;

   // ALUOp values as produced by the controller
   localparam logic [4:0] ALU_ADD  = 5'd0;
   localparam logic [4:0] ALU_SUB  = 5'd1;
   localparam logic [4:0] ALU_AND  = 5'd2;
   localparam logic [4:0] ALU_OR   = 5'd3;
   localparam logic [4:0] ALU_XOR  = 5'd4;
   localparam logic [4:0] ALU_NOR  = 5'd5;
   localparam logic [4:0] ALU_SLT  = 5'd6;
   localparam logic [4:0] ALU_SLTU = 5'd7;
   localparam logic [4:0] ALU_SLL  = 5'd8;
   localparam logic [4:0] ALU_SRL  = 5'd9;
   localparam logic [4:0] ALU_SRA  = 5'd10;
   localparam logic [4:0] ALU_LUI  = 5'd11;

   // Decoded control bundle. An all-zero bundle is a NOP: it writes no
   // register, touches no memory and never branches.
   typedef struct packed {
      logic       reg_write;
      logic       alu_src;
      logic       branch;
      logic       mem_write;
      logic       mem_read;
      logic       zero_ext;
      logic [2:0] jump_ctl;
      logic [2:0] mem_to_reg;
      logic [2:0] reg_dst;
      logic [4:0] alu_op;
   } ctrl_bundle_t;

   localparam ctrl_bundle_t CTRL_NOP = '0;

endpackage : mips_ctrl_pkg

// File: rtl/hazard_unit.sv
// ---------------------------------------------------------------------------
// hazard_unit
//   Purely combinational stall detector for the ID stage.
//   Raises hazard_o when the instruction now in ID cannot proceed:
//     - load-use     : EX holds a load whose result ID reads
//     - branch-EX    : ID compares (beq/bne) or jumps through a register
//                      (jr) that the EX instruction is about to write
//     - branch-MEM   : same compare/jr sources, produced by a load that is
//                      now in MEM and whose data is not forwardable to ID
//   Register $0 is hard-wired to zero and never causes a stall.
//
// Ports
//   id_rs, id_rt         in  ID source register fields
//   id_alu_src           in  ID ALUSrc (0: the ALU reads rt)
//   id_mem_write         in  ID MemWrite (stores read rt as data)
//   id_branch            in  ID Branch (compares rs and rt)
//   id_jump_ctl          in  ID JumpInstCont (JMP_JR reads rs)
//   ex_reg_write         in  EX RegWrite
//   ex_mem_read          in  EX MemRead
//   ex_dest              in  EX resolved write register
//   mem_is_load          in  MEM holds a load
//   mem_dest             in  MEM write register (0 when it writes nothing)
//   hazard_o             out stall request
// ---------------------------------------------------------------------------
module hazard_unit
   import mips_ctrl_pkg::*;
#(
   parameter int REG_AW = 5
)
(
   input  logic [REG_AW-1:0] id_rs,
   input  logic [REG_AW-1:0] id_rt,
   input  logic              id_alu_src,
   input  logic              id_mem_write,
   input  logic              id_branch,
   input  logic [2:0]        id_jump_ctl,
   input  logic              ex_reg_write,
   input  logic              ex_mem_read,
   input  logic [REG_AW-1:0] ex_dest,
   input  logic              mem_is_load,
   input  logic [REG_AW-1:0] mem_dest,
   output logic              hazard_o
);

   logic reads_rt;      // ID instruction consumes rt somewhere in EX/MEM
   logic cmp_in_id;     // ID instruction needs register values in ID itself
   logic ex_dest_live;
   logic mem_dest_live;
   logic ex_hits_rs;
   logic ex_hits_rt;
   logic mem_hits_rs;
   logic mem_hits_rt;
   logic load_use;
   logic branch_ex;
   logic branch_mem;

   always_comb begin
      reads_rt      = ~id_alu_src | id_mem_write;
      cmp_in_id     = id_branch | (id_jump_ctl == JMP_JR);

      ex_dest_live  = (ex_dest  != '0);
      mem_dest_live = (mem_dest != '0);

      ex_hits_rs    = ex_dest_live  & (ex_dest  == id_rs);
      ex_hits_rt    = ex_dest_live  & (ex_dest  == id_rt);
      mem_hits_rs   = mem_dest_live & (mem_dest == id_rs);
      mem_hits_rt   = mem_dest_live & (mem_dest == id_rt);

      load_use      = ex_mem_read & (ex_hits_rs | (reads_rt & ex_hits_rt));

      // jr compares nothing but still needs rs resolved in ID; only a real
      // branch looks at rt.
      branch_ex     = cmp_in_id & ex_reg_write
                      & (ex_hits_rs | (id_branch & ex_hits_rt));
      branch_mem    = cmp_in_id & mem_is_load
                      & (mem_hits_rs | (id_branch & mem_hits_rt));

      hazard_o      = load_use | branch_ex | branch_mem;
   end

endmodule : hazard_unit

// File: rtl/id_ex_stage.sv
// ---------------------------------------------------------------------------
// id_ex_stage
//   ID/EX pipeline register of the 5-stage MIPS datapath, with the stall
//   logic that guards it. Every edge it either captures the ID instruction
//   (control bundle + operands) or loads a bubble (all-zero NOP) when the
//   instruction is flushed or must stall. A one-entry EX/MEM shadow
//   (mem_dest, mem_is_load) remembers what left EX so branch operands can
//   be checked against a load still in MEM.
//
// Ports
//   clk, rst                  clock (rising edge), async active-high reset
//   id_reg_write .. id_alu_op controller control bundle for the ID instr
//   id_rs, id_rt, id_rd       instruction register fields
//   id_rs_data, id_rt_data    register-file read data
//   id_imm                    extended immediate
//   id_pc4                    PC+4 of the ID instruction
//   flush_i                   kill the ID instruction (branch/jump taken)
//   ex_*                      registered copies of the id_* inputs
//   ex_dest                   resolved write register of the EX instr
//   hazard_o                  combinational hold request to IF/ID + ctrl
//   bubble_cnt                saturating count of bubbles inserted
// ---------------------------------------------------------------------------
module id_ex_stage
   import mips_ctrl_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int REG_AW = 5,
   parameter int CNT_W  = 16
)
(
   input  logic              clk,
   input  logic              rst,
   input  logic              id_reg_write,
   input  logic              id_alu_src,
   input  logic              id_branch,
   input  logic              id_mem_write,
   input  logic              id_mem_read,
   input  logic              id_zero_ext,
   input  logic [2:0]        id_jump_ctl,
   input  logic [2:0]        id_mem_to_reg,
   input  logic [2:0]        id_reg_dst,
   input  logic [4:0]        id_alu_op,
   input  logic [REG_AW-1:0] id_rs,
   input  logic [REG_AW-1:0] id_rt,
   input  logic [REG_AW-1:0] id_rd,
   input  logic [DATA_W-1:0] id_rs_data,
   input  logic [DATA_W-1:0] id_rt_data,
   input  logic [DATA_W-1:0] id_imm,
   input  logic [DATA_W-1:0] id_pc4,
   input  logic              flush_i,
   output logic              ex_reg_write,
   output logic              ex_alu_src,
   output logic              ex_branch,
   output logic              ex_mem_write,
   output logic              ex_mem_read,
   output logic              ex_zero_ext,
   output logic [2:0]        ex_jump_ctl,
   output logic [2:0]        ex_mem_to_reg,
   output logic [2:0]        ex_reg_dst,
   output logic [4:0]        ex_alu_op,
   output logic [REG_AW-1:0] ex_rs,
   output logic [REG_AW-1:0] ex_rt,
   output logic [REG_AW-1:0] ex_rd,
   output logic [DATA_W-1:0] ex_rs_data,
   output logic [DATA_W-1:0] ex_rt_data,
   output logic [DATA_W-1:0] ex_imm,
   output logic [DATA_W-1:0] ex_pc4,
   output logic [REG_AW-1:0] ex_dest,
   output logic              hazard_o,
   output logic [CNT_W-1:0]  bubble_cnt
);

   localparam logic [REG_AW-1:0] RA_REG = REG_AW'(31);
   localparam logic [CNT_W-1:0]  CNT_MAX = '1;

   ctrl_bundle_t      id_ctrl;
   ctrl_bundle_t      ex_ctrl;
   logic [REG_AW-1:0] id_dest;
   logic [REG_AW-1:0] mem_dest;
   logic              mem_is_load;
   logic              load_bubble;

   // Gather the loose controller wires into one bundle so the register
   // below moves it as a unit.
   always_comb begin
      id_ctrl            = CTRL_NOP;
      id_ctrl.reg_write  = id_reg_write;
      id_ctrl.alu_src    = id_alu_src;
      id_ctrl.branch     = id_branch;
      id_ctrl.mem_write  = id_mem_write;
      id_ctrl.mem_read   = id_mem_read;
      id_ctrl.zero_ext   = id_zero_ext;
      id_ctrl.jump_ctl   = id_jump_ctl;
      id_ctrl.mem_to_reg = id_mem_to_reg;
      id_ctrl.reg_dst    = id_reg_dst;
      id_ctrl.alu_op     = id_alu_op;
   end

   // Write-register resolution happens at capture so EX and the hazard
   // compare both see a single ready-made destination.
   always_comb begin
      id_dest = '0;
      case (id_reg_dst)
         RD_RT:   id_dest = id_rt;
         RD_RD:   id_dest = id_rd;
         RD_RA:   id_dest = RA_REG;
         default: id_dest = '0;
      endcase
   end

   hazard_unit #(
      .REG_AW (REG_AW)
   ) u_hazard_unit (
      .id_rs        (id_rs),
      .id_rt        (id_rt),
      .id_alu_src   (id_alu_src),
      .id_mem_write (id_mem_write),
      .id_branch    (id_branch),
      .id_jump_ctl  (id_jump_ctl),
      .ex_reg_write (ex_ctrl.reg_write),
      .ex_mem_read  (ex_ctrl.mem_read),
      .ex_dest      (ex_dest),
      .mem_is_load  (mem_is_load),
      .mem_dest     (mem_dest),
      .hazard_o     (hazard_o)
   );

   // Flush and stall both turn into the same bubble, so a flush arriving
   // during a stall is counted once.
   assign load_bubble = flush_i | hazard_o;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ex_ctrl     <= CTRL_NOP;
         ex_rs       <= '0;
         ex_rt       <= '0;
         ex_rd       <= '0;
         ex_rs_data  <= '0;
         ex_rt_data  <= '0;
         ex_imm      <= '0;
         ex_pc4      <= '0;
         ex_dest     <= '0;
         mem_dest    <= '0;
         mem_is_load <= 1'b0;
         bubble_cnt  <= '0;
      end else begin
         // The shadow only remembers a destination that will be written,
         // so a non-writing instruction can never match a source.
         mem_dest    <= ex_ctrl.reg_write ? ex_dest : '0;
         mem_is_load <= ex_ctrl.mem_read;

         if (load_bubble) begin
            ex_ctrl    <= CTRL_NOP;
            ex_rs      <= '0;
            ex_rt      <= '0;
            ex_rd      <= '0;
            ex_rs_data <= '0;
            ex_rt_data <= '0;
            ex_imm     <= '0;
            ex_pc4     <= '0;
            ex_dest    <= '0;
            if (bubble_cnt != CNT_MAX) begin
               bubble_cnt <= bubble_cnt + CNT_W'(1);
            end
         end else begin
            ex_ctrl    <= id_ctrl;
            ex_rs      <= id_rs;
            ex_rt      <= id_rt;
            ex_rd      <= id_rd;
            ex_rs_data <= id_rs_data;
            ex_rt_data <= id_rt_data;
            ex_imm     <= id_imm;
            ex_pc4     <= id_pc4;
            ex_dest    <= id_dest;
         end
      end
   end

   assign ex_reg_write  = ex_ctrl.reg_write;
   assign ex_alu_src    = ex_ctrl.alu_src;
   assign ex_branch     = ex_ctrl.branch;
   assign ex_mem_write  = ex_ctrl.mem_write;
   assign ex_mem_read   = ex_ctrl.mem_read;
   assign ex_zero_ext   = ex_ctrl.zero_ext;
   assign ex_jump_ctl   = ex_ctrl.jump_ctl;
   assign ex_mem_to_reg = ex_ctrl.mem_to_reg;
   assign ex_reg_dst    = ex_ctrl.reg_dst;
   assign ex_alu_op     = ex_ctrl.alu_op;

endmodule : id_ex_stage

// File: tb/tb_id_ex_stage.sv
module tb_id_ex_stage;
   import mips_ctrl_pkg::*;

   // ---------------- clock / reset / signals ----------------
   logic        clk = 1'b0;
   logic        rst;
   logic        id_reg_write, id_alu_src, id_branch, id_mem_write, id_mem_read, id_zero_ext;
   logic [2:0]  id_jump_ctl, id_mem_to_reg, id_reg_dst;
   logic [4:0]  id_alu_op;
   logic [4:0]  id_rs, id_rt, id_rd;
   logic [31:0] id_rs_data, id_rt_data, id_imm, id_pc4;
   logic        flush_i;

   logic        ex_reg_write, ex_alu_src, ex_branch, ex_mem_write, ex_mem_read, ex_zero_ext;
   logic [2:0]  ex_jump_ctl, ex_mem_to_reg, ex_reg_dst;
   logic [4:0]  ex_alu_op;
   logic [4:0]  ex_rs, ex_rt, ex_rd, ex_dest;
   logic [31:0] ex_rs_data, ex_rt_data, ex_imm, ex_pc4;
   logic        hazard_o;
   logic [15:0] bubble_cnt;

   logic        s_reg_write, s_alu_src, s_branch, s_mem_write, s_mem_read, s_zero_ext;
   logic [2:0]  s_jump_ctl, s_mem_to_reg, s_reg_dst;
   logic [4:0]  s_alu_op;
   logic [4:0]  s_rs, s_rt, s_rd, s_dest;
   logic [31:0] s_rs_data, s_rt_data, s_imm, s_pc4;
   logic        s_hazard_o;
   logic [1:0]  s_bubble_cnt;

   int checks   = 0;
   int failures = 0;
   int exp_cnt  = 0;

   always #5 clk = ~clk;

   id_ex_stage dut (
      .clk(clk), .rst(rst),
      .id_reg_write(id_reg_write), .id_alu_src(id_alu_src), .id_branch(id_branch),
      .id_mem_write(id_mem_write), .id_mem_read(id_mem_read), .id_zero_ext(id_zero_ext),
      .id_jump_ctl(id_jump_ctl), .id_mem_to_reg(id_mem_to_reg), .id_reg_dst(id_reg_dst),
      .id_alu_op(id_alu_op), .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
      .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm), .id_pc4(id_pc4),
      .flush_i(flush_i),
      .ex_reg_write(ex_reg_write), .ex_alu_src(ex_alu_src), .ex_branch(ex_branch),
      .ex_mem_write(ex_mem_write), .ex_mem_read(ex_mem_read), .ex_zero_ext(ex_zero_ext),
      .ex_jump_ctl(ex_jump_ctl), .ex_mem_to_reg(ex_mem_to_reg), .ex_reg_dst(ex_reg_dst),
      .ex_alu_op(ex_alu_op), .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd),
      .ex_rs_data(ex_rs_data), .ex_rt_data(ex_rt_data), .ex_imm(ex_imm), .ex_pc4(ex_pc4),
      .ex_dest(ex_dest), .hazard_o(hazard_o), .bubble_cnt(bubble_cnt)
   );

   // Narrow-counter copy sharing all inputs; only its counter is examined.
   id_ex_stage #(.CNT_W(2)) dut_sat (
      .clk(clk), .rst(rst),
      .id_reg_write(id_reg_write), .id_alu_src(id_alu_src), .id_branch(id_branch),
      .id_mem_write(id_mem_write), .id_mem_read(id_mem_read), .id_zero_ext(id_zero_ext),
      .id_jump_ctl(id_jump_ctl), .id_mem_to_reg(id_mem_to_reg), .id_reg_dst(id_reg_dst),
      .id_alu_op(id_alu_op), .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
      .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm), .id_pc4(id_pc4),
      .flush_i(flush_i),
      .ex_reg_write(s_reg_write), .ex_alu_src(s_alu_src), .ex_branch(s_branch),
      .ex_mem_write(s_mem_write), .ex_mem_read(s_mem_read), .ex_zero_ext(s_zero_ext),
      .ex_jump_ctl(s_jump_ctl), .ex_mem_to_reg(s_mem_to_reg), .ex_reg_dst(s_reg_dst),
      .ex_alu_op(s_alu_op), .ex_rs(s_rs), .ex_rt(s_rt), .ex_rd(s_rd),
      .ex_rs_data(s_rs_data), .ex_rt_data(s_rt_data), .ex_imm(s_imm), .ex_pc4(s_pc4),
      .ex_dest(s_dest), .hazard_o(s_hazard_o), .bubble_cnt(s_bubble_cnt)
   );

   // ---------------- EX record and scoreboard queue ----------------
   typedef struct packed {
      ctrl_bundle_t c;
      logic [4:0]   rs, rt, rd;
      logic [31:0]  rs_data, rt_data, imm, pc4;
      logic [4:0]   dest;
   } ex_rec_t;

   localparam int REC_W = $bits(ex_rec_t);
   logic [REC_W-1:0] exp_q[$];

   function automatic ex_rec_t dut_rec();
      ex_rec_t r;
      r.c = {ex_reg_write, ex_alu_src, ex_branch, ex_mem_write, ex_mem_read, ex_zero_ext,
             ex_jump_ctl, ex_mem_to_reg, ex_reg_dst, ex_alu_op};
      r.rs = ex_rs; r.rt = ex_rt; r.rd = ex_rd;
      r.rs_data = ex_rs_data; r.rt_data = ex_rt_data; r.imm = ex_imm; r.pc4 = ex_pc4;
      r.dest = ex_dest;
      return r;
   endfunction

   // ---------------- instruction builders ----------------
   function automatic ctrl_bundle_t mk(input logic rw, input logic as, input logic br,
                                       input logic mw, input logic mr, input logic [2:0] jc,
                                       input logic [2:0] m2r, input logic [2:0] rdst,
                                       input logic [4:0] op);
      ctrl_bundle_t c;
      c = '0;
      c.reg_write = rw; c.alu_src = as; c.branch = br; c.mem_write = mw; c.mem_read = mr;
      c.jump_ctl = jc; c.mem_to_reg = m2r; c.reg_dst = rdst; c.alu_op = op;
      return c;
   endfunction

   function automatic ctrl_bundle_t c_lw();   return mk(1, 1, 0, 0, 1, JMP_NONE, MTR_MEM, RD_RT, ALU_ADD); endfunction
   function automatic ctrl_bundle_t c_add();  return mk(1, 0, 0, 0, 0, JMP_NONE, MTR_ALU, RD_RD, ALU_ADD); endfunction
   function automatic ctrl_bundle_t c_addi(); return mk(1, 1, 0, 0, 0, JMP_NONE, MTR_ALU, RD_RT, ALU_ADD); endfunction
   function automatic ctrl_bundle_t c_beq();  return mk(0, 0, 1, 0, 0, JMP_NONE, MTR_ALU, RD_RT, ALU_SUB); endfunction
   function automatic ctrl_bundle_t c_jal();  return mk(1, 0, 0, 0, 0, JMP_J,    MTR_PC4, RD_RA, ALU_ADD); endfunction

   // ---------------- driver tasks ----------------
   task automatic drive_id(input ctrl_bundle_t c, input logic [4:0] rs, input logic [4:0] rt,
                           input logic [4:0] rd);
      {id_reg_write, id_alu_src, id_branch, id_mem_write, id_mem_read, id_zero_ext,
       id_jump_ctl, id_mem_to_reg, id_reg_dst, id_alu_op} = c;
      id_rs = rs; id_rt = rt; id_rd = rd;
   endtask

   task automatic rand_data();
      id_rs_data = $urandom(); id_rt_data = $urandom();
      id_imm     = $urandom(); id_pc4     = $urandom();
   endtask

   task automatic idle(input int n);
      flush_i = 1'b0;
      drive_id('0, 5'd0, 5'd0, 5'd0);
      repeat (n) @(negedge clk);
   endtask

   // ---------------- reference model ----------------
   // A producer blocks the ID instruction when its written register is
   // non-zero and is one of the registers the ID instruction needs.
   function automatic logic needs(input logic [4:0] r, input logic [4:0] a,
                                  input logic [4:0] b, input logic use_b);
      return (r != 5'd0) && ((r == a) || (use_b && (r == b)));
   endfunction

   function automatic logic ref_hazard(input ctrl_bundle_t c, input logic [4:0] rs,
                                       input logic [4:0] rt, input ex_rec_t ex,
                                       input logic [4:0] md, input logic ml);
      logic reads_rt, early;
      reads_rt = !c.alu_src || c.mem_write;
      early    = c.branch || (c.jump_ctl == JMP_JR);
      return (ex.c.mem_read && needs(ex.dest, rs, rt, reads_rt))
          || (early && ex.c.reg_write && needs(ex.dest, rs, rt, c.branch))
          || (early && ml && needs(md, rs, rt, c.branch));
   endfunction

   function automatic logic [4:0] ref_dest(input logic [2:0] sel, input logic [4:0] rt,
                                           input logic [4:0] rd);
      logic [4:0] choice [0:7];
      choice = '{rt, rd, 5'd31, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0};
      return choice[sel];
   endfunction

   // ---------------- tests ----------------
   task automatic test_reset();
      ex_rec_t zero_rec;
      zero_rec = '0;
      rst = 1'b1; flush_i = 1'b0;
      drive_id('0, 5'd0, 5'd0, 5'd0); rand_data();
      repeat (2) @(negedge clk);
      checks++;
      if (dut_rec() !== zero_rec) begin
         failures++; $display("FAIL reset_ex_regs: got %h want 0", dut_rec());
      end
      checks++;
      if (bubble_cnt !== 16'd0 || hazard_o !== 1'b0) begin
         failures++; $display("FAIL reset_cnt_hazard: got cnt=%0d haz=%0b want 0/0", bubble_cnt, hazard_o);
      end
      rst = 1'b0;
      // build state: one flush bubble, lw $9 in EX, dependent beq in ID
      flush_i = 1'b1; @(negedge clk); flush_i = 1'b0;
      drive_id(c_lw(), 5'd1, 5'd9, 5'd0); rand_data();
      @(negedge clk);
      drive_id(c_beq(), 5'd9, 5'd4, 5'd0);
      #1;
      checks++;
      if (hazard_o !== 1'b1 || bubble_cnt !== 16'd1 || ex_mem_read !== 1'b1) begin
         failures++; $display("FAIL reset_setup: got haz=%0b cnt=%0d mr=%0b want 1/1/1", hazard_o, bubble_cnt, ex_mem_read);
      end
      rst = 1'b1;
      #1;
      checks++;
      if (dut_rec() !== zero_rec || bubble_cnt !== 16'd0 || hazard_o !== 1'b0) begin
         failures++; $display("FAIL reset_async: got rec=%h cnt=%0d haz=%0b want all 0", dut_rec(), bubble_cnt, hazard_o);
      end
      drive_id('0, 5'd0, 5'd0, 5'd0);
      @(negedge clk);
      rst = 1'b0;
      exp_cnt = 0;
   endtask

   task automatic test_load_use();
      logic [31:0] rs_d;
      idle(2);
      drive_id(c_lw(), 5'd1, 5'd8, 5'd0); rand_data();
      #1;
      checks++;
      if (hazard_o !== 1'b0) begin failures++; $display("FAIL lu_no_hazard_lw: got %0b want 0", hazard_o); end
      @(negedge clk);
      drive_id(c_add(), 5'd8, 5'd2, 5'd3); rand_data(); rs_d = id_rs_data;
      #1;
      checks++;
      if (hazard_o !== 1'b1) begin failures++; $display("FAIL lu_hazard: got %0b want 1", hazard_o); end
      @(negedge clk); exp_cnt++;
      checks++;
      if (ex_reg_write !== 1'b0 || ex_mem_read !== 1'b0 || bubble_cnt !== 16'(exp_cnt)) begin
         failures++; $display("FAIL lu_bubble: got rw=%0b mr=%0b cnt=%0d want 0/0/%0d", ex_reg_write, ex_mem_read, bubble_cnt, exp_cnt);
      end
      #1;
      checks++;
      if (hazard_o !== 1'b0) begin failures++; $display("FAIL lu_release: got %0b want 0", hazard_o); end
      @(negedge clk);
      checks++;
      if (ex_reg_write !== 1'b1 || ex_dest !== 5'd3 || ex_rs_data !== rs_d || bubble_cnt !== 16'(exp_cnt)) begin
         failures++; $display("FAIL lu_capture: got rw=%0b dest=%0d rsd=%h cnt=%0d want 1/3/%h/%0d", ex_reg_write, ex_dest, ex_rs_data, bubble_cnt, rs_d, exp_cnt);
      end
   endtask

   task automatic test_branch_after_load();
      idle(2);
      drive_id(c_lw(), 5'd2, 5'd9, 5'd0); rand_data();
      @(negedge clk);
      drive_id(c_beq(), 5'd9, 5'd4, 5'd0);
      for (int k = 0; k < 2; k++) begin
         #1;
         checks++;
         if (hazard_o !== 1'b1) begin failures++; $display("FAIL bl_hazard_%0d: got %0b want 1", k, hazard_o); end
         @(negedge clk); exp_cnt++;
      end
      #1;
      checks++;
      if (hazard_o !== 1'b0 || ex_branch !== 1'b0) begin
         failures++; $display("FAIL bl_release: got haz=%0b br=%0b want 0/0", hazard_o, ex_branch);
      end
      @(negedge clk);
      checks++;
      if (ex_branch !== 1'b1 || ex_rs !== 5'd9 || bubble_cnt !== 16'(exp_cnt)) begin
         failures++; $display("FAIL bl_capture: got br=%0b rs=%0d cnt=%0d want 1/9/%0d", ex_branch, ex_rs, bubble_cnt, exp_cnt);
      end
   endtask

   task automatic test_branch_after_alu();
      idle(2);
      drive_id(c_addi(), 5'd0, 5'd10, 5'd0); rand_data();
      @(negedge clk);
      drive_id(c_beq(), 5'd5, 5'd10, 5'd0);
      #1;
      checks++;
      if (hazard_o !== 1'b1) begin failures++; $display("FAIL ba_hazard: got %0b want 1", hazard_o); end
      @(negedge clk); exp_cnt++;
      #1;
      checks++;
      if (hazard_o !== 1'b0) begin failures++; $display("FAIL ba_one_cycle: got %0b want 0", hazard_o); end
      @(negedge clk);
      checks++;
      if (ex_branch !== 1'b1 || ex_rt !== 5'd10 || bubble_cnt !== 16'(exp_cnt)) begin
         failures++; $display("FAIL ba_capture: got br=%0b rt=%0d cnt=%0d want 1/10/%0d", ex_branch, ex_rt, bubble_cnt, exp_cnt);
      end
      // writes to $0 never stall
      drive_id(c_addi(), 5'd3, 5'd0, 5'd0);
      @(negedge clk);
      drive_id(c_beq(), 5'd0, 5'd0, 5'd0);
      #1;
      checks++;
      if (hazard_o !== 1'b0) begin failures++; $display("FAIL ba_r0: got %0b want 0", hazard_o); end
      @(negedge clk);
      checks++;
      if (ex_branch !== 1'b1 || bubble_cnt !== 16'(exp_cnt)) begin
         failures++; $display("FAIL ba_r0_capture: got br=%0b cnt=%0d want 1/%0d", ex_branch, bubble_cnt, exp_cnt);
      end
   endtask

   task automatic test_flush_vs_stall();
      idle(2);
      drive_id(c_lw(), 5'd1, 5'd8, 5'd0); rand_data();
      @(negedge clk);
      drive_id(c_add(), 5'd8, 5'd2, 5'd3); flush_i = 1'b1;
      #1;
      checks++;
      if (hazard_o !== 1'b1) begin failures++; $display("FAIL fs_hazard: got %0b want 1", hazard_o); end
      @(negedge clk); exp_cnt++;
      flush_i = 1'b0;
      checks++;
      if (ex_reg_write !== 1'b0 || bubble_cnt !== 16'(exp_cnt)) begin
         failures++; $display("FAIL fs_single_count: got rw=%0b cnt=%0d want 0/%0d", ex_reg_write, bubble_cnt, exp_cnt);
      end
      drive_id(c_jal(), 5'd0, 5'd0, 5'd0); rand_data();
      @(negedge clk);
      checks++;
      if (ex_dest !== 5'd31 || ex_mem_to_reg !== 3'd2 || ex_jump_ctl !== 3'd1 || ex_reg_write !== 1'b1) begin
         failures++; $display("FAIL jal_capture: got dest=%0d m2r=%0d jc=%0d rw=%0b want 31/2/1/1", ex_dest, ex_mem_to_reg, ex_jump_ctl, ex_reg_write);
      end
   endtask

   task automatic test_saturation();
      @(negedge clk);
      #1 rst = 1'b1;
      #1 rst = 1'b0;
      drive_id('0, 5'd0, 5'd0, 5'd0);
      flush_i = 1'b1;
      for (int k = 1; k <= 5; k++) begin
         @(negedge clk);
         checks++;
         if (bubble_cnt !== 16'(k) || s_bubble_cnt !== 2'((k > 3) ? 3 : k)) begin
            failures++; $display("FAIL sat_%0d: got wide=%0d narrow=%0d want %0d/%0d", k, bubble_cnt, s_bubble_cnt, k, (k > 3) ? 3 : k);
         end
      end
      flush_i = 1'b0;
   endtask

   task automatic test_random();
      ex_rec_t          m_ex, got;
      logic [REC_W-1:0] exp_bits;
      logic [4:0]       m_md, n_md;
      logic             m_ml, n_ml, mh, hold;
      int               m_cnt;
      ctrl_bundle_t     c;
      logic [19:0]      raw;
      logic [4:0]       rs, rt, rd;
      @(negedge clk);
      #1 rst = 1'b1;
      #1 rst = 1'b0;
      m_ex = '0; m_md = '0; m_ml = 1'b0; m_cnt = 0; hold = 1'b0;
      c = '0; rs = '0; rt = '0; rd = '0;
      exp_q.delete();
      for (int i = 0; i < 400; i++) begin
         @(negedge clk);
         if (exp_q.size() > 0) begin
            exp_bits = exp_q.pop_front();
            got = dut_rec();
            checks++;
            if (got !== ex_rec_t'(exp_bits)) begin
               failures++; $display("FAIL rand_ex_%0d: got %h want %h", i, got, exp_bits);
            end
         end
         checks++;
         if (bubble_cnt !== 16'(m_cnt)) begin
            failures++; $display("FAIL rand_cnt_%0d: got %0d want %0d", i, bubble_cnt, m_cnt);
         end
         if (!hold) begin
            raw = 20'($urandom());
            c   = ctrl_bundle_t'(raw);
            rs  = 5'($urandom_range(0, 3));
            rt  = 5'($urandom_range(0, 3));
            rd  = 5'($urandom_range(0, 3));
            drive_id(c, rs, rt, rd); rand_data();
         end
         flush_i = ($urandom_range(0, 7) == 0);
         #1;
         mh = ref_hazard(c, rs, rt, m_ex, m_md, m_ml);
         checks++;
         if (hazard_o !== mh) begin
            failures++; $display("FAIL rand_hazard_%0d: got %0b want %0b", i, hazard_o, mh);
         end
         // advance the model across the coming clock edge
         n_md = m_ex.c.reg_write ? m_ex.dest : 5'd0;
         n_ml = m_ex.c.mem_read;
         if (flush_i || mh) begin
            m_ex = '0;
            if (m_cnt < 65535) m_cnt++;
         end else begin
            m_ex.c = c; m_ex.rs = rs; m_ex.rt = rt; m_ex.rd = rd;
            m_ex.rs_data = id_rs_data; m_ex.rt_data = id_rt_data;
            m_ex.imm = id_imm; m_ex.pc4 = id_pc4;
            m_ex.dest = ref_dest(c.reg_dst, rt, rd);
         end
         m_md = n_md; m_ml = n_ml;
         exp_q.push_back(m_ex);
         hold = mh && !flush_i;
      end
      @(negedge clk);
      flush_i = 1'b0;
      exp_bits = exp_q.pop_front();
      checks++;
      if (dut_rec() !== ex_rec_t'(exp_bits)) begin
         failures++; $display("FAIL rand_ex_last: got %h want %h", dut_rec(), exp_bits);
      end
   endtask

   // ---------------- sequence and report ----------------
   initial begin
      rst = 1'b1;
      flush_i = 1'b0;
      drive_id('0, 5'd0, 5'd0, 5'd0);
      rand_data();
      test_reset();
      test_load_use();
      test_branch_after_load();
      test_branch_after_alu();
      test_flush_vs_stall();
      test_saturation();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule : tb_id_ex_stage
